// File: rtl/pr_decouple_ctrl.sv
`timescale 1ns/1ps
// pr_decouple_ctrl
//
// Sequences a partial reconfiguration of the "pr" region while the shell
// datapath stays up. On request, both stream directions are drained to a
// packet boundary (or forced after a drain timeout). The streams are then
// isolated and the region is held in reset. After reconfiguration the reset
// is released, the region gets one settle cycle, and the streams reconnect.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RUN        | streams connected, region out of reset, waiting for request
// DRAIN      | in-flight packets finish; idle directions refuse new packets
// DECOUPLED  | streams isolated, region in reset, waiting for reconfig_done
// RELEASE    | streams isolated, region held in reset for RESET_CYCLES
// RESTART    | region out of reset, streams still isolated for one cycle
//
// Ports
//   CLK, ARESETN            clock, async active-low reset
//   reconfig_req            start a decouple sequence (looked at in RUN only)
//   reconfig_done           bitstream loaded (looked at in DECOUPLED only)
//   pr_resetn               active-low reset to the pr region
//   decouple_status         streams isolated
//   busy                    sequencer not in RUN
//   timeout_err             sticky: the last drain was forced by the timeout
//   S_AXIS_*   -> M_PR_AXIS_*   ingress stream, shell to region
//   S_PR_AXIS_* -> M_AXIS_*     egress stream, region to shell
//
// Data, keep and last always pass straight through; only valid/ready are
// gated. Gating is a function of registered state and the per-direction
// in_pkt flags only, so request/done inputs never reach tready/tvalid
// combinationally.

module pr_decouple_ctrl #(
  parameter int DATA_WIDTH    = 512,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int RESET_CYCLES  = 16
) (
  input  logic                    CLK,
  input  logic                    ARESETN,

  input  logic                    reconfig_req,
  input  logic                    reconfig_done,
  output logic                    pr_resetn,
  output logic                    decouple_status,
  output logic                    busy,
  output logic                    timeout_err,

  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic                    S_AXIS_tlast,
  input  logic                    S_AXIS_tvalid,
  output logic                    S_AXIS_tready,

  output logic [DATA_WIDTH-1:0]   M_PR_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_PR_AXIS_tkeep,
  output logic                    M_PR_AXIS_tlast,
  output logic                    M_PR_AXIS_tvalid,
  input  logic                    M_PR_AXIS_tready,

  input  logic [DATA_WIDTH-1:0]   S_PR_AXIS_tdata,
  input  logic [DATA_WIDTH/8-1:0] S_PR_AXIS_tkeep,
  input  logic                    S_PR_AXIS_tlast,
  input  logic                    S_PR_AXIS_tvalid,
  output logic                    S_PR_AXIS_tready,

  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready
);

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_DRAIN     = 3'd1;
  localparam logic [2:0] ST_DECOUPLED = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RESTART   = 3'd4;

  // One counter serves both the drain timeout and the release interval, so
  // it must be wide enough for the larger of the two terminal counts.
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int REL_W   = $clog2(RESET_CYCLES + 1);
  localparam int CNT_W   = (DRAIN_W > REL_W) ? DRAIN_W : REL_W;

  localparam logic [CNT_W-1:0] DRAIN_TC = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] REL_TC   = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_nxt;

  logic             ing_in_pkt;
  logic             egr_in_pkt;
  logic             link_off;
  logic             ing_gate;
  logic             egr_gate;
  logic             ing_hs;
  logic             egr_hs;

  // Any state other than RUN/DRAIN (including unused encodings) isolates.
  assign link_off = (state != ST_RUN) && (state != ST_DRAIN);

  // In DRAIN a direction that sits between packets refuses the next first
  // beat; a direction mid-packet keeps flowing until its tlast beat.
  assign ing_gate = link_off || ((state == ST_DRAIN) && !ing_in_pkt);
  assign egr_gate = link_off || ((state == ST_DRAIN) && !egr_in_pkt);

  assign M_PR_AXIS_tdata  = S_AXIS_tdata;
  assign M_PR_AXIS_tkeep  = S_AXIS_tkeep;
  assign M_PR_AXIS_tlast  = S_AXIS_tlast;
  assign M_PR_AXIS_tvalid = S_AXIS_tvalid && !ing_gate;
  assign S_AXIS_tready    = M_PR_AXIS_tready && !ing_gate;

  assign M_AXIS_tdata     = S_PR_AXIS_tdata;
  assign M_AXIS_tkeep     = S_PR_AXIS_tkeep;
  assign M_AXIS_tlast     = S_PR_AXIS_tlast;
  assign M_AXIS_tvalid    = S_PR_AXIS_tvalid && !egr_gate;
  assign S_PR_AXIS_tready = M_AXIS_tready && !egr_gate;

  assign ing_hs = S_AXIS_tvalid && S_AXIS_tready;
  assign egr_hs = S_PR_AXIS_tvalid && S_PR_AXIS_tready;

  assign pr_resetn       = (state == ST_RUN) || (state == ST_DRAIN) ||
                           (state == ST_RESTART);
  assign decouple_status = link_off;
  assign busy            = (state != ST_RUN);

  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_nxt = timeout_err;
    case (state)
      ST_RUN: begin
        if (reconfig_req) begin
          state_nxt   = ST_DRAIN;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt_inc;
        // A clean boundary wins over a timeout landing on the same edge.
        if (!ing_in_pkt && !egr_in_pkt) begin
          state_nxt = ST_DECOUPLED;
        end else if (cnt_inc == DRAIN_TC) begin
          state_nxt   = ST_DECOUPLED;
          timeout_nxt = 1'b1;
        end
      end
      ST_DECOUPLED: begin
        if (reconfig_done) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == REL_TC) begin
          state_nxt = ST_RESTART;
        end
      end
      ST_RESTART: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RELEASE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= ST_RELEASE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  // A forced drain leaves a truncated packet behind; dropping the flags in
  // DECOUPLED makes the region restart from a packet boundary.
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ing_in_pkt <= 1'b0;
      egr_in_pkt <= 1'b0;
    end else if (state == ST_DECOUPLED) begin
      ing_in_pkt <= 1'b0;
      egr_in_pkt <= 1'b0;
    end else begin
      if (ing_hs) begin
        ing_in_pkt <= !S_AXIS_tlast;
      end
      if (egr_hs) begin
        egr_in_pkt <= !S_PR_AXIS_tlast;
      end
    end
  end

endmodule

// File: tb/tb_pr_decouple_ctrl.sv
`timescale 1ns/1ps
module tb_pr_decouple_ctrl;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int DT = 32;
  localparam int RC = 16;

  typedef logic [DW+KW:0] beat_t;

  logic          CLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          reconfig_req = 1'b0;
  logic          reconfig_done = 1'b0;
  logic          pr_resetn, decouple_status, busy, timeout_err;
  logic [DW-1:0] S_AXIS_tdata = '0;
  logic [KW-1:0] S_AXIS_tkeep = '0;
  logic          S_AXIS_tlast = 1'b0;
  logic          S_AXIS_tvalid = 1'b0;
  logic          S_AXIS_tready;
  logic [DW-1:0] M_PR_AXIS_tdata;
  logic [KW-1:0] M_PR_AXIS_tkeep;
  logic          M_PR_AXIS_tlast, M_PR_AXIS_tvalid;
  logic          M_PR_AXIS_tready = 1'b1;
  logic [DW-1:0] S_PR_AXIS_tdata = '0;
  logic [KW-1:0] S_PR_AXIS_tkeep = '0;
  logic          S_PR_AXIS_tlast = 1'b0;
  logic          S_PR_AXIS_tvalid = 1'b0;
  logic          S_PR_AXIS_tready;
  logic [DW-1:0] M_AXIS_tdata;
  logic [KW-1:0] M_AXIS_tkeep;
  logic          M_AXIS_tlast, M_AXIS_tvalid;
  logic          M_AXIS_tready = 1'b1;

  beat_t q_ing[$];
  beat_t q_egr[$];
  beat_t e_ing, e_egr;
  int    total = 0;
  int    bad = 0;
  bit    acc;

  pr_decouple_ctrl #(
    .DATA_WIDTH(DW), .DRAIN_TIMEOUT(DT), .RESET_CYCLES(RC)
  ) dut (
    .CLK(CLK), .ARESETN(ARESETN),
    .reconfig_req(reconfig_req), .reconfig_done(reconfig_done),
    .pr_resetn(pr_resetn), .decouple_status(decouple_status),
    .busy(busy), .timeout_err(timeout_err),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
    .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready),
    .M_PR_AXIS_tdata(M_PR_AXIS_tdata), .M_PR_AXIS_tkeep(M_PR_AXIS_tkeep),
    .M_PR_AXIS_tlast(M_PR_AXIS_tlast), .M_PR_AXIS_tvalid(M_PR_AXIS_tvalid),
    .M_PR_AXIS_tready(M_PR_AXIS_tready),
    .S_PR_AXIS_tdata(S_PR_AXIS_tdata), .S_PR_AXIS_tkeep(S_PR_AXIS_tkeep),
    .S_PR_AXIS_tlast(S_PR_AXIS_tlast), .S_PR_AXIS_tvalid(S_PR_AXIS_tvalid),
    .S_PR_AXIS_tready(S_PR_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep),
    .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output side of the scoreboard: every delivered beat must match the
  // oldest beat the bench expects on that direction.
  always @(negedge CLK) begin
    if (M_PR_AXIS_tvalid && M_PR_AXIS_tready) begin
      if (q_ing.size() == 0) chk("ing_unexpected_beat", 1, 0);
      else begin
        e_ing = q_ing.pop_front();
        chk("ing_beat", {M_PR_AXIS_tdata, M_PR_AXIS_tkeep, M_PR_AXIS_tlast}, e_ing);
      end
    end
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      if (q_egr.size() == 0) chk("egr_unexpected_beat", 1, 0);
      else begin
        e_egr = q_egr.pop_front();
        chk("egr_beat", {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast}, e_egr);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_streams();
    S_AXIS_tvalid    = 1'b0;
    S_PR_AXIS_tvalid = 1'b0;
  endtask

  // Drive one beat, expect it on the far side, and wait (bounded) for the
  // handshake. A refused beat is withdrawn from the scoreboard.
  task automatic send_beat(input bit egr, input logic [DW-1:0] d, input logic l,
                           input int max_wait, output bit ok);
    logic [KW-1:0] k;
    k  = d[KW-1:0] | 4'b0001;
    ok = 1'b0;
    if (!egr) begin
      S_AXIS_tdata = d; S_AXIS_tkeep = k; S_AXIS_tlast = l; S_AXIS_tvalid = 1'b1;
      q_ing.push_back({d, k, l});
    end else begin
      S_PR_AXIS_tdata = d; S_PR_AXIS_tkeep = k; S_PR_AXIS_tlast = l; S_PR_AXIS_tvalid = 1'b1;
      q_egr.push_back({d, k, l});
    end
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge CLK);
      if (egr ? S_PR_AXIS_tready : S_AXIS_tready) ok = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (!ok) begin
      if (!egr) begin S_AXIS_tvalid = 1'b0; void'(q_ing.pop_back()); end
      else begin S_PR_AXIS_tvalid = 1'b0; void'(q_egr.pop_back()); end
    end
  endtask

  task automatic wait_run(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < RC + 8 && !seen; i++) begin
      tick();
      if (!busy) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic finish_sequence(input string tag);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    wait_run(tag);
  endtask

  // Count the release interval exactly from a known edge in RELEASE (cnt=0).
  task automatic check_release(input string tag);
    repeat (RC - 1) tick();
    chk({tag, "_prrst_low_last"}, pr_resetn, 0);
    tick();
    chk({tag, "_prrst_high"}, pr_resetn, 1);
    chk({tag, "_restart_gated"}, S_AXIS_tready, 0);
    chk({tag, "_restart_busy"}, busy, 1);
    tick();
    chk({tag, "_run_busy"}, busy, 0);
    chk({tag, "_run_ready"}, S_AXIS_tready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up: values during reset with traffic offered on both sides.
    S_AXIS_tvalid = 1'b1;
    S_PR_AXIS_tvalid = 1'b1;
    #23;
    chk("rst_prrst", pr_resetn, 0);
    chk("rst_decouple", decouple_status, 1);
    chk("rst_busy", busy, 1);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_s_ready", S_AXIS_tready, 0);
    chk("rst_mpr_valid", M_PR_AXIS_tvalid, 0);
    chk("rst_m_valid", M_AXIS_tvalid, 0);
    idle_streams();
    tick();
    ARESETN = 1'b1;
    check_release("pwrup");

    // Plain pass-through in RUN, both directions.
    send_beat(0, 32'h0000_0A11, 0, 4, acc); chk("run_ing_acc0", acc, 1);
    send_beat(0, 32'h0000_0A12, 1, 4, acc); chk("run_ing_acc1", acc, 1);
    idle_streams();
    send_beat(1, 32'h0000_0B21, 1, 4, acc); chk("run_egr_acc", acc, 1);
    idle_streams();

    // reconfig_done ignored in RUN.
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    tick();
    chk("done_in_run_busy", busy, 0);

    // Idle request: DRAIN on the sampling edge, DECOUPLED the edge after.
    reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    chk("idle_drain_busy", busy, 1);
    chk("idle_drain_decouple", decouple_status, 0);
    chk("idle_drain_gated", S_AXIS_tready, 0);
    tick();
    chk("idle_decoupled", decouple_status, 1);
    chk("idle_decoupled_prrst", pr_resetn, 0);
    // reconfig_req ignored in DECOUPLED.
    reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    tick();
    chk("req_in_dec_status", decouple_status, 1);
    chk("req_in_dec_prrst", pr_resetn, 0);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    check_release("idle_rel");

    // Mid-packet drain: request sampled with beat 3.
    for (int b = 1; b <= 8; b++) begin
      if (b == 3) reconfig_req = 1'b1;
      send_beat(0, 32'h0000_0100 + b, (b == 8), 4, acc);
      if (b == 3) reconfig_req = 1'b0;
      chk("mid_beat_acc", acc, 1);
    end
    send_beat(0, 32'h0000_0200, 0, 3, acc);
    chk("mid_next_pkt_refused", acc, 0);
    chk("mid_decoupled", decouple_status, 1);
    chk("mid_no_timeout", timeout_err, 0);
    finish_sequence("mid_back_to_run");

    // Forced drain: egress packet stalls with M_AXIS_tready low.
    send_beat(1, 32'h0000_0E01, 0, 4, acc); chk("to_first_acc", acc, 1);
    M_AXIS_tready = 1'b0;
    S_PR_AXIS_tdata = 32'h0000_0E02;
    S_PR_AXIS_tlast = 1'b1;
    S_PR_AXIS_tvalid = 1'b1;
    reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    repeat (DT - 1) tick();
    chk("to_still_drain", decouple_status, 0);
    chk("to_err_early", timeout_err, 0);
    tick();
    chk("to_forced_dec", decouple_status, 1);
    chk("to_err_set", timeout_err, 1);
    chk("to_egr_gated", S_PR_AXIS_tready, 0);
    idle_streams();
    M_AXIS_tready = 1'b1;
    finish_sequence("to_back_to_run");
    chk("to_err_sticky", timeout_err, 1);

    // Request held across the return to RUN; egress in_pkt must be cleared.
    reconfig_req = 1'b1;
    tick();
    chk("held_drain_busy", busy, 1);
    chk("held_err_cleared", timeout_err, 0);
    tick();
    chk("held_egr_flag_cleared", decouple_status, 1);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    repeat (RC - 1) tick();
    chk("held_prrst_low", pr_resetn, 0);
    tick();
    chk("held_prrst_high", pr_resetn, 1);
    tick();
    chk("held_run", busy, 0);
    tick();
    chk("held_redrain_busy", busy, 1);
    chk("held_redrain_dec", decouple_status, 0);
    reconfig_req = 1'b0;
    tick();
    chk("held_redecoupled", decouple_status, 1);
    finish_sequence("held_back_to_run");

    // Egress packet after the forced drain.
    send_beat(1, 32'h0000_0E10, 0, 4, acc); chk("post_to_egr0", acc, 1);
    send_beat(1, 32'h0000_0E11, 1, 4, acc); chk("post_to_egr1", acc, 1);
    idle_streams();

    // Reset in DRAIN while an ingress packet is open.
    send_beat(0, 32'h0000_0301, 0, 4, acc); chk("rm_acc0", acc, 1);
    reconfig_req = 1'b1;
    send_beat(0, 32'h0000_0302, 0, 4, acc); chk("rm_acc1", acc, 1);
    reconfig_req = 1'b0;
    chk("rm_in_drain", decouple_status, 0);
    chk("rm_open_pkt_flows", S_AXIS_tready, 1);
    S_AXIS_tdata = 32'h0000_0303;
    S_AXIS_tlast = 1'b0;
    S_AXIS_tvalid = 1'b1;
    #2;
    ARESETN = 1'b0;
    #1;
    chk("rm_gated_ready", S_AXIS_tready, 0);
    chk("rm_gated_valid", M_PR_AXIS_tvalid, 0);
    chk("rm_prrst", pr_resetn, 0);
    chk("rm_decouple", decouple_status, 1);
    chk("rm_busy", busy, 1);
    idle_streams();
    tick();
    tick();
    ARESETN = 1'b1;
    check_release("rm_rel");
    // in_pkt must have been cleared by reset: an idle drain finishes at once.
    reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    tick();
    chk("rm_flag_cleared", decouple_status, 1);
    finish_sequence("rm_back_to_run");
    send_beat(0, 32'h0000_0401, 1, 4, acc); chk("rm_post_acc", acc, 1);
    idle_streams();
    tick();
    tick();

    chk("ing_queue_empty", q_ing.size(), 0);
    chk("egr_queue_empty", q_egr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
